// File: rtl/alu_pkg.sv
// alu_pkg: types and constants shared by the ALU and the writeback stage.
//   FLAG_*      bit positions of {N,Z,C,V} inside a 4-bit flag vector
//   OVF_CNT_*   width and saturation value of the overflow event counter
//   wb_entry_t  one ALU result as it travels to the register file
package alu_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 5;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int OVF_CNT_W = 16;
    localparam logic [OVF_CNT_W-1:0] OVF_CNT_MAX = '1;

    typedef struct packed {
        logic [WB_DATA_W-1:0] data;
        logic [WB_ADDR_W-1:0] dest;
        logic                 wrEn;
        logic                 setFlags;
        logic [3:0]           flags;   // {N,Z,C,V}
    } wb_entry_t;

    // Increment that sticks at the maximum instead of wrapping.
    function automatic logic [OVF_CNT_W-1:0] sat_inc(input logic [OVF_CNT_W-1:0] v);
        return (v == OVF_CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/wb_skid_fifo.sv
// wb_skid_fifo: 2-entry FIFO of wb_entry_t.
//   clk, reset_n  clock, synchronous active-low reset (empties, zeroes storage)
//   push_i        write push_data_i (ignored when full)
//   pop_i         retire the head (ignored when empty)
//   head_o        oldest entry; zero after reset
//   count_o       occupancy 0..2
// Entry 0 is always the head, so the output needs no read mux.
module wb_skid_fifo
    import alu_pkg::*;
(
    input  logic      clk,
    input  logic      reset_n,
    input  logic      push_i,
    input  wb_entry_t push_data_i,
    input  logic      pop_i,
    output wb_entry_t head_o,
    output logic [1:0] count_o
);

    wb_entry_t  e0_q, e0_d;
    wb_entry_t  e1_q, e1_d;
    logic [1:0] count_q, count_d;

    logic push_ok, pop_ok;

    assign push_ok = push_i && (count_q != 2'd2);
    assign pop_ok  = pop_i  && (count_q != 2'd0);

    always_comb begin
        e0_d    = e0_q;
        e1_d    = e1_q;
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10: begin
                if (count_q == 2'd0) e0_d = push_data_i;
                else                 e1_d = push_data_i;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                e0_d    = e1_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Only reachable with count 1: the new entry replaces the head.
                e0_d = push_data_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            e0_q    <= '0;
            e1_q    <= '0;
            count_q <= 2'd0;
        end else begin
            e0_q    <= e0_d;
            e1_q    <= e1_d;
            count_q <= count_d;
        end
    end

    assign head_o  = e0_q;
    assign count_o = count_q;

endmodule

// File: rtl/alu_writeback_stage.sv
// alu_writeback_stage: buffers ALU results for the register-file write port
// and commits flags / overflow events in retirement order.
//   clk, reset_n                 clock, synchronous active-low reset
//   inValid/inReady              upstream handshake; inReady is registered-only
//   inData, inDest, inWrEn,
//   inSetFlags, *Flag            result, destination and ALU flags
//   outValid/outReady            register-file handshake
//   outData, outDest, outWrEn    head entry; writes to r0 are masked
//   statusFlags                  committed {N,Z,C,V}
//   ovfCount                     saturating count of committed overflows
// DATA_W/ADDR_W must match the widths of alu_pkg::wb_entry_t.
module alu_writeback_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              inValid,
    output logic              inReady,
    input  logic [DATA_W-1:0] inData,
    input  logic [ADDR_W-1:0] inDest,
    input  logic              inWrEn,
    input  logic              inSetFlags,
    input  logic              zeroFlag,
    input  logic              overflowFlag,
    input  logic              carryoutFlag,
    input  logic              negativeFlag,
    output logic              outValid,
    input  logic              outReady,
    output logic [DATA_W-1:0] outData,
    output logic [ADDR_W-1:0] outDest,
    output logic              outWrEn,
    output logic [3:0]        statusFlags,
    output logic [15:0]       ovfCount
);

    wb_entry_t  in_entry, head;
    logic [1:0] count;
    logic       push, pop;

    logic [3:0]           status_q, status_d;
    logic [OVF_CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

    always_comb begin
        in_entry              = '0;
        in_entry.data         = inData;
        in_entry.dest         = inDest;
        in_entry.wrEn         = inWrEn;
        in_entry.setFlags     = inSetFlags;
        in_entry.flags[FLAG_N] = negativeFlag;
        in_entry.flags[FLAG_Z] = zeroFlag;
        in_entry.flags[FLAG_C] = carryoutFlag;
        in_entry.flags[FLAG_V] = overflowFlag;
    end

    assign inReady  = (count != 2'd2);
    assign outValid = (count != 2'd0);
    assign push     = inValid && inReady;
    assign pop      = outValid && outReady;

    wb_skid_fifo u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (push),
        .push_data_i (in_entry),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (count)
    );

    assign outData = head.data;
    assign outDest = head.dest;
    // r0 is hardwired; the entry still retires, it just never writes.
    assign outWrEn = head.wrEn && (head.dest != '0);

    // Flags commit at retirement so they follow program order.
    always_comb begin
        status_d  = status_q;
        ovf_cnt_d = ovf_cnt_q;
        if (pop && head.setFlags) begin
            status_d = head.flags;
            if (head.flags[FLAG_V]) ovf_cnt_d = sat_inc(ovf_cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            status_q  <= 4'b0000;
            ovf_cnt_q <= '0;
        end else begin
            status_q  <= status_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign statusFlags = status_q;
    assign ovfCount    = ovf_cnt_q;

endmodule

// File: doc/alu_writeback_stage.md
# alu_writeback_stage

Result/flag capture stage directly downstream of the ALU (compare, add, logic units). Accepts one ALU result per cycle, with its zero/overflow/carryout/negative flags and destination register, through a valid/ready handshake. Buffers up to two results in a skid buffer and presents them to the register-file write port. Commits flags to an architectural NZCV status register and counts overflow events in program order.

## Interface
Parameters:
- DATA_W, 32, result width
- ADDR_W, 5, destination register index width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset_n  in  1  reset, synchronous, active-low
- inValid  in  1  ALU result valid
- inReady  out  1  stage can accept an entry
- inData  in  DATA_W  ALU dataOut
- inDest  in  ADDR_W  destination register
- inWrEn  in  1  result is to be written
- inSetFlags  in  1  result updates the status register
- zeroFlag, overflowFlag, carryoutFlag, negativeFlag  in  1 each  ALU flags for inData
- outValid  out  1  write-port entry valid
- outReady  in  1  register file accepts the entry
- outData  out  DATA_W  write data
- outDest  out  ADDR_W  write address
- outWrEn  out  1  write enable for the presented entry
- statusFlags  out  4  committed {N,Z,C,V}
- ovfCount  out  16  saturating count of committed overflows

## Operation
- Storage: 2-entry FIFO. Each entry holds {data, dest, wrEn, setFlags, N, Z, C, V}. Occupancy count is 0..2.
- Push: occurs when inValid && inReady. Captures all in* signals and the four flags.
- Pop: occurs when outValid && outReady. Head entry retires.
- inReady = (count != 2). It is driven from registered state only and has no combinational path from outReady.
- outValid = (count != 0). outData, outDest and outWrEn always reflect the head entry.
- outWrEn = head.wrEn && (head.dest != 0). Register 0 is never written, but the entry is still presented and popped normally.
- Flag commit happens at pop, not push, to keep retirement order.
  - If head.setFlags is set, statusFlags <= {N,Z,C,V} of the head.
  - If head.setFlags is clear, statusFlags are unchanged.
- ovfCount increments by 1 on a pop where head.setFlags && head.V. It saturates at 16'hFFFF and never wraps.
- Data from inData passes unmodified. No arithmetic is performed on the result.
- Reset (reset_n low at a rising edge) produces:
  - count=0, outValid=0, outData=0, outDest=0, outWrEn=0
  - inReady=1, statusFlags=4'b0000, ovfCount=0
- Reset mid-operation discards all buffered entries. No pop, flag commit or counter increment occurs on the reset edge.

## Timing
- Latency: an entry pushed at edge k is presented (outValid=1) in the cycle after edge k. There is no fall-through in the same cycle.
- Throughput: 1 entry/cycle while outReady stays high. The count remains at 1 under continuous push and pop.
- Simultaneous push and pop:
  - count=1: the head advances to the new entry and count stays 1.
  - count=2: inReady=0, so only the pop occurs and count becomes 1. inReady rises the next cycle.
  - count=0: only the push can occur. Pop is impossible because outValid=0.
- Output hold: while outValid && !outReady, outData, outDest and outWrEn must remain stable.
- statusFlags and ovfCount change in the cycle after the popping edge.
- inValid while inReady=0 is ignored. The upstream holds its data until accepted.

## Structure
- Shared package alu_pkg holds:
  - flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
  - OVF_CNT_W=16 and OVF_CNT_MAX
  - packed entry struct wb_entry_t (data, dest, wrEn, setFlags, flags[3:0]); the ALU and this stage both use it
- One sub-module, wb_skid_fifo: a 2-entry FIFO of wb_entry_t with push/pop/count, head output, and the synchronous active-low reset.
- The top level adds the register-0 write suppression, the status register and the overflow counter.

## Test plan
- Reset then idle:
  - all outputs at their reset values, inReady=1
  - push {data=32'h1, dest=3, wrEn=1, setFlags=1, N=0,Z=0,C=0,V=0} -> outValid=1 next cycle, outData=1, outDest=3, outWrEn=1
  - pop -> statusFlags=0000
- Backpressure: hold outReady=0 and push 3 entries (A, B, C) -> count reaches 2 and inReady=0. C is held by the source, and outputs stay on A. Then release outReady -> A, B, C retire in order on consecutive cycles.
- Dest 0: push {dest=0, wrEn=1, data=32'hDEAD} -> outValid=1, outWrEn=0, and the entry pops normally.
- Flag ordering: push X{setFlags=1, Z=1} then Y{setFlags=0, N=1}, then pop both -> statusFlags=0100 after X and still 0100 after Y.
- Overflow saturation: force ovfCount to 16'hFFFE, then pop 3 entries with setFlags=1, V=1 -> ovfCount goes FFFF, FFFF, FFFF.
- Reset with count=2 and outReady=1 on the reset edge -> no flag update, ovfCount unchanged at 0. Next cycle: outValid=0, inReady=1.
